// File: rtl/z_raster_scheduler_pkg.sv
// Shared types and state encodings for the triangle raster scheduler.
// Holds the defines_package contents (Point2D, Triangle3D, FSM states) as a compilable package.
package z_raster_scheduler_pkg;

  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
  } Point2D;

  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] z;
  } Point3D;

  typedef struct packed {
    Point3D v0;
    Point3D v1;
    Point3D v2;
  } Triangle3D;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StSetup   = 3'd1;
  localparam logic [2:0] StIssue   = 3'd2;
  localparam logic [2:0] StWait    = 3'd3;
  localparam logic [2:0] StEmit    = 3'd4;
  localparam logic [2:0] StAdvance = 3'd5;
  localparam logic [2:0] StDone    = 3'd6;

  function automatic logic signed [15:0] smin(input logic signed [15:0] a,
                                              input logic signed [15:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic signed [15:0] smax(input logic signed [15:0] a,
                                              input logic signed [15:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/z_raster_scheduler_bbox.sv
// raster_bbox: combinational bounding box of a triangle, clipped to the screen.
// skip flags triangles that must produce no fragments (zero area or fully off-screen).
module raster_bbox
  import z_raster_scheduler_pkg::*;
#(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  Triangle3D          tri_in,
  output logic signed [15:0] minx,
  output logic signed [15:0] miny,
  output logic signed [15:0] maxx,
  output logic signed [15:0] maxy,
  output logic               skip
);

  localparam logic signed [15:0] XLast = 16'(SCREEN_W - 1);
  localparam logic signed [15:0] YLast = 16'(SCREEN_H - 1);

  logic signed [15:0] ux_min, ux_max, uy_min, uy_max;

  always_comb begin
    ux_min = smin(smin(tri_in.v0.x, tri_in.v1.x), tri_in.v2.x);
    ux_max = smax(smax(tri_in.v0.x, tri_in.v1.x), tri_in.v2.x);
    uy_min = smin(smin(tri_in.v0.y, tri_in.v1.y), tri_in.v2.y);
    uy_max = smax(smax(tri_in.v0.y, tri_in.v1.y), tri_in.v2.y);

    minx = smax(ux_min, 16'sd0);
    miny = smax(uy_min, 16'sd0);
    maxx = smin(ux_max, XLast);
    maxy = smin(uy_max, YLast);

    // Zero area is judged on the unclipped box; emptiness on the clipped one.
    skip = (ux_min == ux_max) || (uy_min == uy_max) || (minx > maxx) || (miny > maxy);
  end

endmodule

// File: rtl/z_raster_scheduler.sv
// Walks the clipped bounding box of each accepted triangle pixel by pixel, querying the
// depth interpolation unit and emitting a fragment for every pixel reported inside.
module z_raster_scheduler
  import z_raster_scheduler_pkg::*;
#(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tri_valid,
  output logic               tri_ready,
  input  Triangle3D          tri_in,
  output Triangle3D          zi_triangle,
  output Point2D             zi_point,
  output logic               zi_start,
  input  logic               zi_done,
  input  logic signed [15:0] zi_z,
  input  logic               zi_inside,
  output logic               frag_valid,
  input  logic               frag_ready,
  output logic signed [15:0] frag_x,
  output logic signed [15:0] frag_y,
  output logic signed [15:0] frag_z,
  output logic               tri_done
);

  logic [2:0]         state_q, state_d;
  Triangle3D          tri_q, tri_d;
  Point2D             cur_q, cur_d;
  logic signed [15:0] minx_q, minx_d, maxx_q, maxx_d, maxy_q, maxy_d;
  logic signed [15:0] fx_q, fx_d, fy_q, fy_d, fz_q, fz_d;

  logic signed [15:0] bb_minx, bb_miny, bb_maxx, bb_maxy;
  logic               bb_skip;

  raster_bbox #(
    .SCREEN_W(SCREEN_W),
    .SCREEN_H(SCREEN_H)
  ) u_bbox (
    .tri_in(tri_q),
    .minx  (bb_minx),
    .miny  (bb_miny),
    .maxx  (bb_maxx),
    .maxy  (bb_maxy),
    .skip  (bb_skip)
  );

  always_comb begin
    state_d = state_q;
    tri_d   = tri_q;
    cur_d   = cur_q;
    minx_d  = minx_q;
    maxx_d  = maxx_q;
    maxy_d  = maxy_q;
    fx_d    = fx_q;
    fy_d    = fy_q;
    fz_d    = fz_q;
    unique case (state_q)
      StIdle: begin
        if (tri_valid) begin
          tri_d   = tri_in;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (bb_skip) begin
          state_d = StDone;
        end else begin
          minx_d  = bb_minx;
          maxx_d  = bb_maxx;
          maxy_d  = bb_maxy;
          cur_d.x = bb_minx;
          cur_d.y = bb_miny;
          state_d = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (zi_done) begin
          if (zi_inside) begin
            fx_d    = cur_q.x;
            fy_d    = cur_q.y;
            fz_d    = zi_z;
            state_d = StEmit;
          end else begin
            state_d = StAdvance;
          end
        end
      end
      StEmit: begin
        if (frag_ready) state_d = StAdvance;
      end
      StAdvance: begin
        // Cursor never exceeds the clipped box, so +1 cannot overflow.
        if (cur_q.x == maxx_q) begin
          if (cur_q.y == maxy_q) begin
            state_d = StDone;
          end else begin
            cur_d.x = minx_q;
            cur_d.y = cur_q.y + 16'sd1;
            state_d = StIssue;
          end
        end else begin
          cur_d.x = cur_q.x + 16'sd1;
          state_d = StIssue;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      tri_q   <= '0;
      cur_q   <= '0;
      minx_q  <= '0;
      maxx_q  <= '0;
      maxy_q  <= '0;
      fx_q    <= '0;
      fy_q    <= '0;
      fz_q    <= '0;
    end else begin
      state_q <= state_d;
      tri_q   <= tri_d;
      cur_q   <= cur_d;
      minx_q  <= minx_d;
      maxx_q  <= maxx_d;
      maxy_q  <= maxy_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
      fz_q    <= fz_d;
    end
  end

  always_comb begin
    tri_ready   = (state_q == StIdle);
    zi_start    = (state_q == StIssue);
    frag_valid  = (state_q == StEmit);
    tri_done    = (state_q == StDone);
    zi_triangle = tri_q;
    zi_point    = cur_q;
    frag_x      = fx_q;
    frag_y      = fy_q;
    frag_z      = fz_q;
  end

endmodule
